// File: rtl/dmi_req_ctrl.sv
// DMI request controller: one outstanding downstream transaction, sticky status, optional timeout.
// Latency: accepted pulse -> dm_req_valid next cycle; response -> status/rdata/busy next cycle; holds request under dm_req_ready low.
module dmi_req_ctrl #(
  parameter int AWIDTH         = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_wr_en,
  input  logic              req_rd_en,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_write,
  output logic [AWIDTH-1:0] dm_req_addr,
  output logic [31:0]       dm_req_wdata,
  input  logic              dm_rsp_valid,
  input  logic              dm_rsp_err,
  input  logic [31:0]       dm_rsp_rdata,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic [1:0] STAT_OK   = 2'd0;
  localparam logic [1:0] STAT_FAIL = 2'd2;
  localparam logic [1:0] STAT_BUSY = 2'd3;

  localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              write;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  logic [1:0]    state, state_nxt;
  req_t          req_q, req_nxt;
  logic [31:0]   rdata_q, rdata_nxt;
  logic [1:0]    status_q, status_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;

  logic req_any;
  logic in_flight;
  logic accept;
  logic timed_out;
  logic fail_evt;
  logic coll_evt;

  assign req_any   = req_wr_en | req_rd_en;
  assign in_flight = (state != ST_IDLE);
  // dmi_reset in the same cycle clears the status, so it re-opens the door for a new request.
  assign accept    = !dmi_hard_reset && (state == ST_IDLE) && req_any &&
                     ((status_q == STAT_OK) || dmi_reset);
  // The counter value is the number of cycles already spent outstanding, so this fires on the last allowed one.
  assign timed_out = TO_EN && in_flight && (cnt_q == TO_LAST);
  assign coll_evt  = in_flight && req_any;

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    rdata_nxt  = rdata_q;
    status_nxt = dmi_reset ? STAT_OK : status_q;
    cnt_nxt    = cnt_q;
    fail_evt   = 1'b0;

    if (in_flight && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + 1'b1;
    end

    if (dmi_hard_reset) begin
      state_nxt  = ST_IDLE;
      status_nxt = STAT_OK;
      cnt_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nxt     = ST_REQ;
            cnt_nxt       = '0;
            req_nxt.write = req_wr_en;
            req_nxt.addr  = req_addr;
            req_nxt.wdata = req_wdata;
          end
        end
        ST_REQ: begin
          if (timed_out) begin
            state_nxt = ST_IDLE;
            fail_evt  = 1'b1;
          end else if (dm_req_ready) begin
            state_nxt = ST_RSP;
          end
        end
        ST_RSP: begin
          if (timed_out) begin
            state_nxt = ST_IDLE;
            fail_evt  = 1'b1;
          end else if (dm_rsp_valid) begin
            state_nxt = ST_IDLE;
            if (!req_q.write) begin
              rdata_nxt = dm_rsp_rdata;
            end
            fail_evt = dm_rsp_err;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      // First error wins; a transaction failure outranks a same-cycle collision.
      if (status_nxt == STAT_OK) begin
        if (fail_evt) begin
          status_nxt = STAT_FAIL;
        end else if (coll_evt) begin
          status_nxt = STAT_BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      rdata_q  <= '0;
      status_q <= STAT_OK;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      req_q    <= req_nxt;
      rdata_q  <= rdata_nxt;
      status_q <= status_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign dm_req_valid = (state == ST_REQ);
  assign dm_req_write = req_q.write;
  assign dm_req_addr  = req_q.addr;
  assign dm_req_wdata = req_q.wdata;
  assign rsp_rdata    = rdata_q;
  assign rsp_status   = status_q;
  assign busy         = in_flight;

endmodule
